ssd_value_selector: RTL
=======================

Name: ssd_value_selector

Overview:
- Upstream feeder for the 4-digit seven-segment driver; produces the 13-bit value it displays.
- Takes four 32-bit CPU debug sources: PC, instruction, ALU result and memory read data.
- A debounced push-button steps through the sources as "pages". The selected value is re-sampled at a slow human-readable rate, saturated to 0–8191, and held stable between samples.
- Sits between the CPU core's debug taps and the display driver in the FPGA top level.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles needed to accept a button level change (10 ms @ 100 MHz).
- SAMPLE_CYCLES, 25_000_000, period in clk cycles between periodic captures of the selected source (4 Hz @ 100 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_next_i  input  1  raw asynchronous push-button, active-high; a press advances the page
- freeze_i  input  1  switch; when 1, suppresses periodic re-sampling
- pc_i  input  32  page 0 source
- inst_i  input  32  page 1 source
- alu_result_i  input  32  page 2 source
- mem_data_i  input  32  page 3 source
- num_o  output  13  value to the display driver (0–8191)
- page_o  output  2  current page, for board LEDs
- ovf_o  output  1  1 when the captured source exceeded 8191 and num_o is saturated

Behaviour:
- Reset (async, rst=1): num_o=0, page_o=0, ovf_o=0, sample timer=0, synchronizer flops=0, debouncer in IDLE_LOW with counter=0.
- Synchronizer: btn_next_i passes through a 2-FF synchronizer before any other use.
- Debouncer FSM, counter width = clog2(DEBOUNCE_CYCLES+1):
  - IDLE_LOW: go to WAIT_HIGH when sync=1, clearing the counter.
  - WAIT_HIGH: count while sync=1. sync=0 returns to IDLE_LOW. When the counter reaches DEBOUNCE_CYCLES-1 with sync=1, go to HELD_HIGH and emit a 1-cycle press pulse.
  - HELD_HIGH: go to WAIT_LOW when sync=0, clearing the counter.
  - WAIT_LOW: count while sync=0. sync=1 returns to HELD_HIGH. Reaching DEBOUNCE_CYCLES-1 goes to IDLE_LOW.
  - Exactly one press pulse per accepted press, regardless of hold time. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Page: on the press pulse, page_o <= page_o+1, wrapping mod 4 (3 -> 0).
- Capture event, registered: num_o/ovf_o load from mux(source selected by page).
  - Saturation: if src[31:13]!=0 then num_o=8191 and ovf_o=1; else num_o=src[12:0] and ovf_o=0.
- Capture triggers:
  - Page-change capture: occurs the cycle after page_o changes, using the new page. Applies regardless of freeze_i. Restarts the sample timer at 0.
  - Periodic capture: the timer counts 0..SAMPLE_CYCLES-1 and wraps. On the terminal count, capture occurs if freeze_i=0. The timer runs even when frozen.
- Simultaneous events: a page-change capture and a periodic terminal count in the same cycle produce one capture from the new page, and the timer restarts at 0.
- Between captures, num_o, page_o and ovf_o are held constant. Source inputs need not be stable.
- Latency, button edge -> page_o: 2 sync cycles + DEBOUNCE_CYCLES. page_o -> num_o: 1 cycle.
- A reset mid-debounce or mid-period discards all progress. No press is registered from a button held through reset until it is released and pressed again.

Decomposition:
- Shared package ssd_pkg holds:
  - page encodings PAGE_PC=2'd0, PAGE_INST=2'd1, PAGE_ALU=2'd2, PAGE_MEM=2'd3
  - NUM_MAX=13'd8191
  - debouncer state encodings
- One sub-module, button_debouncer: synchronizer + FSM + counter, outputs press_o. It is reusable for other board buttons.
- Page counter, sample timer, mux and saturation logic stay in ssd_value_selector.

Test Plan (DEBOUNCE_CYCLES=4, SAMPLE_CYCLES=8):
- Reset, then pc_i=0x0000_1234, freeze_i=0, run 8 cycles -> num_o=13'd4660 (0x1234) after the first terminal count; page_o=0; ovf_o=0.
- btn_next_i high for 2 cycles then low -> no page change; page_o stays 0; no extra capture.
- btn_next_i held high for 20 cycles, inst_i=0x0000_0FFF -> page_o=1 exactly once, 6 cycles after the edge; num_o=4095 one cycle later; the timer restarts.
- Four clean presses from page 0 -> page_o sequence 1,2,3,0; with alu_result_i=32'd9000 on page 2 -> num_o=8191 and ovf_o=1.
- freeze_i=1 on page 0, change pc_i from 100 to 200 across three periods -> num_o stays 100. A press to page 1 still captures inst_i. freeze_i=0 -> the next terminal count captures the current value.
- Assert rst mid-WAIT_HIGH and while num_o=8191 -> all outputs go to 0 asynchronously. A button still held after release of rst yields no page change until it is released and pressed again.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared page encodings, display limit and debouncer states for the SSD value selector
package ssd_pkg;
   localparam logic [1:0] PAGE_PC   = 2'd0;
   localparam logic [1:0] PAGE_INST = 2'd1;
   localparam logic [1:0] PAGE_ALU  = 2'd2;
   localparam logic [1:0] PAGE_MEM  = 2'd3;
   localparam logic [12:0] NUM_MAX  = 13'd8191;
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW} db_state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchronizer plus debounce FSM emitting one press pulse per accepted press
module button_debouncer
   import ssd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync_q, prm_q;
   logic armed_q, sync;
   db_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   assign sync = sync_q[1];
   // armed only once the synchronizer holds real samples and has seen the button low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         prm_q   <= '0;
         armed_q <= 1'b0;
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         prm_q   <= {prm_q[0], 1'b1};
         armed_q <= armed_q | (prm_q[1] & ~sync);
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_o = 1'b0;
      case (state_q)
         IDLE_LOW:
            if (sync && armed_q) begin
               state_d = WAIT_HIGH;
               cnt_d   = '0;
            end
         WAIT_HIGH:
            if (!sync) state_d = IDLE_LOW;
            else if (cnt_q == LAST) begin
               state_d = HELD_HIGH;
               press_o = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         HELD_HIGH:
            if (!sync) begin
               state_d = WAIT_LOW;
               cnt_d   = '0;
            end
         WAIT_LOW:
            if (sync) state_d = HELD_HIGH;
            else if (cnt_q == LAST) state_d = IDLE_LOW;
            else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE_LOW;
      endcase
   end
endmodule

// File: rtl/ssd_value_selector.sv
// ssd_value_selector: button-paged CPU debug source, sampled slowly and saturated to 13 bits
module ssd_value_selector
   import ssd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SAMPLE_CYCLES   = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_next_i,
   input  logic        freeze_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] mem_data_i,
   output logic [12:0] num_o,
   output logic [1:0]  page_o,
   output logic        ovf_o
);
   localparam int TW = $clog2(SAMPLE_CYCLES + 1);
   logic press, chg_q, tc, cap, sat;
   logic [TW-1:0] tmr_q;
   logic [31:0] src;
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_next_i),
      .press_o (press)
   );
   assign tc  = tmr_q == TW'(SAMPLE_CYCLES - 1);
   assign cap = chg_q | (tc & ~freeze_i);
   assign sat = |src[31:13];
   always_comb src = page_o == PAGE_PC   ? pc_i :
                     page_o == PAGE_INST ? inst_i :
                     page_o == PAGE_ALU  ? alu_result_i : mem_data_i;
   // chg_q delays the press so the capture sees the already-advanced page
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         page_o <= PAGE_PC;
         chg_q  <= 1'b0;
         tmr_q  <= '0;
         num_o  <= '0;
         ovf_o  <= 1'b0;
      end else begin
         page_o <= page_o + {1'b0, press};
         chg_q  <= press;
         tmr_q  <= (chg_q | tc) ? '0 : tmr_q + 1'b1;
         if (cap) begin
            ovf_o <= sat;
            num_o <= sat ? NUM_MAX : src[12:0];
         end
      end
   end
endmodule
